dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of requester and memory ports.
REQ-002 Parameter DATA_W, default 32: data width of requester and memory ports.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-low.
REQ-005 rK_req_i  in  1  access request from requester K (K = 0 for CPU, K = 1 for DMA/debug).
REQ-006 rK_we_i  in  1  1 = write, 0 = read, for requester K.
REQ-007 rK_addr_i  in  ADDR_W  byte address, requester K.
REQ-008 rK_wdata_i  in  DATA_W  write data, requester K.
REQ-009 rK_gnt_o  out  1  one-cycle pulse: request K accepted this cycle.
REQ-010 rK_rvalid_o  out  1  one-cycle pulse: response for K; read data valid or write acknowledged.
REQ-011 rK_rdata_o  out  DATA_W  read data; qualified by rK_rvalid_o.
REQ-012 rK_err_o  out  1  error flag; qualified by rK_rvalid_o.
REQ-013 mem_addr_o  out  ADDR_W  address to data memory.
REQ-014 mem_data_o  out  DATA_W  write data to data memory.
REQ-015 mem_read_o  out  1  memory read strobe.
REQ-016 mem_write_o  out  1  memory write strobe.
REQ-017 mem_data_i  in  DATA_W  memory read data, valid one cycle after the read strobe is sampled.
REQ-018 busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and RESP.
- IDLE -> ACCESS when any rK_req_i is high.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-020 In IDLE with a request pending, the block SHALL assert rK_gnt_o combinationally for the winner and latch its we, addr and wdata on that edge.
REQ-021 Arbitration SHALL be two-way round-robin.
- A sole requester wins.
- On a tie, the requester not granted most recently wins.
- The last-grant register resets to 1, so requester 0 wins the first tie.
REQ-022 During ACCESS only, the block SHALL drive the latched address and data on mem_addr_o and mem_data_o, and assert exactly one of mem_read_o or mem_write_o for exactly one cycle.
REQ-023 Outside ACCESS, mem_read_o, mem_write_o, mem_addr_o and mem_data_o SHALL be 0.
REQ-024 In RESP, the block SHALL pulse rvalid_o for the latched winner only.
- Read: rdata_o = mem_data_i.
- Write: rdata_o = 0.
- rdata_o is 0 whenever rvalid_o is low.
REQ-025 Timing: gnt in cycle N, memory strobe in cycle N+1, rvalid in cycle N+2; next gnt no earlier than N+3; peak throughput one access per 3 cycles.
REQ-026 A requester SHALL hold req and its operands stable until gnt; the block ignores req outside IDLE and ignores operand changes after gnt.
REQ-027 A requester still asserting req after its response SHALL be treated as a new request.
REQ-028 The block SHALL never assert gnt to both requesters in the same cycle.

Reset
REQ-029 Asserting rst_i SHALL asynchronously force: state IDLE, last-grant = 1, all latched operands 0, all outputs 0.
REQ-030 Reset asserted mid-operation SHALL abort the access, with no rvalid issued for it; after release, a pending memory strobe is not reissued.

Configuration
REQ-031 With DMEM_ARB_ALIGN_CHECK_EN defined, a granted request with addr[1:0] != 2'b00 SHALL:
- receive gnt normally;
- suppress both memory strobes in ACCESS;
- in RESP, pulse rvalid_o with err_o = 1 and rdata_o = 0.
REQ-032 Without DMEM_ARB_ALIGN_CHECK_EN, all addresses SHALL be forwarded unchanged and err_o SHALL be tied to 0.

Structure
REQ-033 The shared package dmem_arb_pkg SHALL hold:
- the state enum (IDLE/ACCESS/RESP);
- the requester-id type (1 bit);
- the reset value of last-grant.
REQ-034 The round-robin picker SHALL be a sub-module rr_arb2, with inputs req[1:0] and last and outputs gnt[1:0]; it is purely combinational.

Verification
REQ-035 Single read: r0 reads addr 0x8, memory returns 0xDEADBEEF -> r0_gnt_o at N, mem_read_o at N+1 with mem_addr_o = 0x8, r0_rvalid_o at N+2 with r0_rdata_o = 0xDEADBEEF.
REQ-036 Write then read: r1 writes 0x12345678 to 0x10, then reads 0x10 -> mem_write_o at N+1 with mem_data_o = 0x12345678, write ack with rdata 0, then read returns 0x12345678.
REQ-037 Contention: r0 and r1 hold req continuously for 4 accesses -> grant order r0, r1, r0, r1, spaced 3 cycles apart, never simultaneous.
REQ-038 Reset mid-op: rst_i low during ACCESS of an r0 read -> all outputs 0 immediately, no r0_rvalid_o; after release, an r1 request is granted first cycle.
REQ-039 Misaligned access: r0 reads 0x6 -> with DMEM_ARB_ALIGN_CHECK_EN, no memory strobe and r0_err_o = 1 at N+2; without it, mem_read_o with addr 0x6 and err 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the two-port data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  // Last-grant points at requester 1 out of reset so requester 0 wins the first tie.
  localparam req_id_t LAST_GNT_RST = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output logic [1:0] gnt
);

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || (last == 1'b1))) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter in front of a single-port data memory
// Optional alignment check enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              r0_req_i,
  input  logic              r0_we_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_gnt_o,
  output logic              r0_rvalid_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  output logic              r0_err_o,

  input  logic              r1_req_i,
  input  logic              r1_we_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_gnt_o,
  output logic              r1_rvalid_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  output logic              r1_err_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_data_i,

  output logic              busy_o
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  req_id_t           last_q;
  req_id_t           id_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        arb_gnt;
  logic [1:0]        gnt_vec;
  logic              misalign;
  logic [DATA_W-1:0] resp_data;

  rr_arb2 u_rr_arb2 (
    .req  ({r1_req_i, r0_req_i}),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Grants are gated by reset so every output reads 0 while reset is held.
  assign gnt_vec  = ((state_q == ST_IDLE) && rst_i) ? arb_gnt : 2'b00;
  assign r0_gnt_o = gnt_vec[0];
  assign r1_gnt_o = gnt_vec[1];

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misalign = (addr_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_GNT_RST;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_vec != 2'b00) begin
        id_q    <= gnt_vec[1];
        last_q  <= gnt_vec[1];
        we_q    <= gnt_vec[1] ? r1_we_i    : r0_we_i;
        addr_q  <= gnt_vec[1] ? r1_addr_i  : r0_addr_i;
        wdata_q <= gnt_vec[1] ? r1_wdata_i : r0_wdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (r0_req_i || r1_req_i) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Writes and rejected accesses return zero data.
  assign resp_data = (we_q || misalign) ? '0 : mem_data_i;

  always_comb begin
    mem_addr_o  = '0;
    mem_data_o  = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    r0_rvalid_o = 1'b0;
    r1_rvalid_o = 1'b0;
    r0_rdata_o  = '0;
    r1_rdata_o  = '0;
    r0_err_o    = 1'b0;
    r1_err_o    = 1'b0;
    busy_o      = (state_q != ST_IDLE);
    if (state_q == ST_ACCESS) begin
      mem_addr_o  = addr_q;
      mem_data_o  = wdata_q;
      mem_read_o  = !we_q && !misalign;
      mem_write_o = we_q && !misalign;
    end
    if (state_q == ST_RESP) begin
      if (id_q == 1'b0) begin
        r0_rvalid_o = 1'b1;
        r0_rdata_o  = resp_data;
        r0_err_o    = misalign;
      end else begin
        r1_rvalid_o = 1'b1;
        r1_rdata_o  = resp_data;
        r1_err_o    = misalign;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vectors plus randomized traffic against a transaction-level model
module tb_dmem_arbiter;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [1:0]  err;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
  } obs_t;

  typedef struct {
    int          k;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_data, mem_data_i;
  logic        mem_read, mem_write, busy;

  logic [31:0] ram [16];
  logic        ram_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .r0_req_i    (req[0]),
    .r0_we_i     (we[0]),
    .r0_addr_i   (addr[0]),
    .r0_wdata_i  (wdata[0]),
    .r0_gnt_o    (r0_gnt),
    .r0_rvalid_o (r0_rvalid),
    .r0_rdata_o  (r0_rdata),
    .r0_err_o    (r0_err),
    .r1_req_i    (req[1]),
    .r1_we_i     (we[1]),
    .r1_addr_i   (addr[1]),
    .r1_wdata_i  (wdata[1]),
    .r1_gnt_o    (r1_gnt),
    .r1_rvalid_o (r1_rvalid),
    .r1_rdata_o  (r1_rdata),
    .r1_err_o    (r1_err),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_data_i  (mem_data_i),
    .busy_o      (busy)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 2) ? 32'hDEAD_BEEF : 32'h1000_0000 + i;
  endfunction

  // Memory device: read data appears one cycle after the read strobe is sampled.
  always @(posedge clk_i) begin
    if (!ram_ready) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
      ram_ready  <= 1'b1;
      mem_data_i <= '0;
    end else begin
      if (mem_write) ram[mem_addr[5:2]] <= mem_data;
      if (mem_read)  mem_data_i <= ram[mem_addr[5:2]];
    end
  end

  function automatic obs_t sample();
    obs_t o;
    o.gnt    = {r1_gnt, r0_gnt};
    o.rvalid = {r1_rvalid, r0_rvalid};
    o.err    = {r1_err, r0_err};
    o.rdata0 = r0_rdata;
    o.rdata1 = r1_rdata;
    o.rd     = mem_read;
    o.wr     = mem_write;
    o.addr   = mem_addr;
    o.wdata  = mem_data;
    o.busy   = busy;
    return o;
  endfunction

  task automatic chk_obs(input string nm, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    req[k]   = r;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  // Starts and ends at a drive point (just after a rising edge).
  task automatic do_single(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rdata, input logic exp_err, input logic strobe);
    obs_t e;
    drive(k, 1'b1, w, a, d);
    @(negedge clk_i);
    e = '0;
    e.gnt = (k == 1) ? 2'b10 : 2'b01;
    chk_obs($sformatf("gnt r%0d a=%h", k, a), sample(), e);
    @(posedge clk_i); #1;
    drive(k, 1'b0, ~w, a ^ 32'hFF, ~d);
    @(negedge clk_i);
    e = '0;
    e.busy = 1'b1;
    e.rd = strobe && !w;
    e.wr = strobe && w;
    e.addr = a;
    e.wdata = d;
    chk_obs($sformatf("access r%0d a=%h", k, a), sample(), e);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    e = '0;
    e.busy = 1'b1;
    e.rvalid[k] = 1'b1;
    e.err[k] = exp_err;
    if (k == 1) e.rdata1 = exp_rdata;
    else        e.rdata0 = exp_rdata;
    chk_obs($sformatf("resp r%0d a=%h", k, a), sample(), e);
    @(posedge clk_i); #1;
    drive(k, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    vec_t        tbl [5];
    obs_t        e;
    logic [31:0] mem_m [16];
    logic        pend [2];
    logic        p_we [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd [2];
    int          last, g, gk, w;
    logic        inflight, g_we, granted;
    logic [31:0] g_addr, g_wd, g_rd;

    tbl[0] = '{0, 1'b0, 32'h08, 32'h0,         32'hDEAD_BEEF};
    tbl[1] = '{1, 1'b1, 32'h10, 32'h1234_5678, 32'h0};
    tbl[2] = '{1, 1'b0, 32'h10, 32'h0,         32'h1234_5678};
    tbl[3] = '{0, 1'b1, 32'h3C, 32'hCAFE_F00D, 32'h0};
    tbl[4] = '{1, 1'b0, 32'h3C, 32'h0,         32'hCAFE_F00D};

    rst_i = 1'b0;
    for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, '0, '0);
    #12;
    drive(0, 1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    chk_obs("reset outputs", sample(), '0);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Contention: both hold req; first tie after reset goes to r0.
    drive(0, 1'b1, 1'b0, 32'h0, 32'h11);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h22);
    for (int c = 0; c < 12; c++) begin
      w = (c / 3) % 2;
      @(negedge clk_i);
      e = '0;
      case (c % 3)
        0: e.gnt = (w == 1) ? 2'b10 : 2'b01;
        1: begin
          e.busy = 1'b1;
          e.rd = 1'b1;
          e.addr = (w == 1) ? 32'h4 : 32'h0;
          e.wdata = (w == 1) ? 32'h22 : 32'h11;
        end
        default: begin
          e.busy = 1'b1;
          e.rvalid[w] = 1'b1;
          if (w == 1) e.rdata1 = init_word(1);
          else        e.rdata0 = init_word(0);
        end
      endcase
      chk_obs($sformatf("contend c%0d", c), sample(), e);
      @(posedge clk_i); #1;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    for (int i = 0; i < 5; i++)
      do_single(tbl[i].k, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, 1'b0, 1'b1);

    // Reset during ACCESS of an r0 read.
    drive(0, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk_i);
    e = '0;
    e.gnt = 2'b01;
    chk_obs("rstmid gnt", sample(), e);
    @(posedge clk_i); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    #2;
    rst_i = 1'b0;
    #1;
    chk_obs("rstmid outputs", sample(), '0);
    @(posedge clk_i); #1;
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk_i);
    chk_obs("rstmid held", sample(), '0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    do_single(1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 1'b1);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    do_single(0, 1'b0, 32'h6, 32'h55, 32'h0, 1'b1, 1'b0);
    do_single(1, 1'b1, 32'h13, 32'h77, 32'h0, 1'b1, 1'b0);
`else
    do_single(0, 1'b0, 32'h6, 32'h55, init_word(1), 1'b0, 1'b1);
`endif

    // Randomized traffic against the transaction-level model.
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = ram[i];
    last = 1;
    inflight = 1'b0;
    g = 0; gk = 0; g_we = 1'b0; g_addr = '0; g_wd = '0; g_rd = '0;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; p_we[k] = 1'b0; p_addr[k] = '0; p_wd[k] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k]   = 1'b1;
          p_we[k]   = 1'($urandom_range(0, 1));
          p_addr[k] = 32'($urandom_range(0, 15)) * 4;
          p_wd[k]   = $urandom;
        end
        if (pend[k]) drive(k, 1'b1, p_we[k], p_addr[k], p_wd[k]);
        else         drive(k, 1'b0, 1'b0, '0, '0);
      end
      e = '0;
      granted = 1'b0;
      if (inflight && c == g + 1) begin
        e.busy = 1'b1;
        e.rd = !g_we;
        e.wr = g_we;
        e.addr = g_addr;
        e.wdata = g_wd;
      end
      if (inflight && c == g + 2) begin
        e.busy = 1'b1;
        e.rvalid[gk] = 1'b1;
        if (gk == 1) e.rdata1 = g_rd;
        else         e.rdata0 = g_rd;
      end
      if ((!inflight || c >= g + 3) && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
        e.gnt = (w == 1) ? 2'b10 : 2'b01;
        granted = 1'b1;
        inflight = 1'b1;
        g = c; gk = w; g_we = p_we[w]; g_addr = p_addr[w]; g_wd = p_wd[w];
        g_rd = g_we ? 32'h0 : mem_m[g_addr[5:2]];
        if (g_we) mem_m[g_addr[5:2]] = g_wd;
        last = w;
      end
      @(negedge clk_i);
      chk_obs($sformatf("rand c%0d", c), sample(), e);
      if (granted) pend[w] = 1'b0;
      @(posedge clk_i); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
